// File: rtl/fifo_window_reader_if.sv
// +--------------------------------------------------------------------------+
// | fifo_window_reader_if : FIFO drain + window handshake bundle             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface fifo_window_reader_if #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 3
);
  logic                   buffer_full;
  logic                   no_config;
  logic [DATA_W-1:0]      fifo_data;
  logic                   pop;
  logic [TAPS*DATA_W-1:0] win_data;
  logic                   win_valid;
  logic                   win_ready;
  logic                   busy;
  logic                   burst_done;
`ifdef FIFO_WINDOW_READER_SUM_EN
  logic [DATA_W+$clog2(TAPS)-1:0] window_sum;

  modport master (
    input  buffer_full, no_config, fifo_data, win_ready,
    output pop, win_data, win_valid, busy, burst_done, window_sum
  );
  modport slave (
    output buffer_full, no_config, fifo_data, win_ready,
    input  pop, win_data, win_valid, busy, burst_done, window_sum
  );
`else
  modport master (
    input  buffer_full, no_config, fifo_data, win_ready,
    output pop, win_data, win_valid, busy, burst_done
  );
  modport slave (
    output buffer_full, no_config, fifo_data, win_ready,
    input  pop, win_data, win_valid, busy, burst_done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/fifo_window_reader.sv
// +--------------------------------------------------------------------------+
// | fifo_window_reader : drains BURST FIFO entries into a TAPS-wide window   |
// | Optional macro FIFO_WINDOW_READER_SUM_EN adds a registered window_sum.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fifo_window_reader #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 3,
  parameter int BURST  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_window_reader_if.master bus_if
);

  localparam int CNT_W  = $clog2(BURST + 1);
  localparam int FILL_W = $clog2(TAPS + 1);
  localparam int WIN_W  = TAPS * DATA_W;
  localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST);
  localparam logic [FILL_W-1:0] TAPS_CNT  = FILL_W'(TAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_data_q, win_data_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
  logic               pop_q;
  logic               win_valid_q;
  logic               busy_q;
  logic               w_handshake;
  logic               w_last;

`ifdef FIFO_WINDOW_READER_SUM_EN
  localparam int SUM_W = DATA_W + $clog2(TAPS);
  logic [SUM_W-1:0]   sum_q, sum_d;
`endif

  assign w_handshake = win_valid_q & bus_if.win_ready;
  assign w_last      = (pop_cnt_q == BURST_CNT);

  always_comb begin
    state_d    = state_q;
    win_data_d = win_data_q;
    fill_cnt_d = fill_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus_if.buffer_full && !bus_if.no_config) begin
          state_d    = POP;
          fill_cnt_d = '0;
          pop_cnt_d  = '0;
        end
      end
      POP: begin
        pop_cnt_d = pop_cnt_q + 1'b1;
        state_d   = CAPT;
      end
      CAPT: begin
        // Newest sample enters the low slice; the oldest falls off the top.
        win_data_d = {win_data_q[(TAPS-1)*DATA_W-1:0], bus_if.fifo_data};
        if (fill_cnt_q != TAPS_CNT) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
        state_d = (fill_cnt_d == TAPS_CNT) ? OUT : POP;
      end
      OUT: begin
        if (w_handshake) begin
          state_d = w_last ? IDLE : POP;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FIFO_WINDOW_READER_SUM_EN
    sum_d = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum_d = sum_d + SUM_W'(win_data_d[i*DATA_W +: DATA_W]);
    end
`endif
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_data_q  <= '0;
      fill_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      pop_q       <= 1'b0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FIFO_WINDOW_READER_SUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      win_data_q  <= win_data_d;
      fill_cnt_q  <= fill_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      pop_q       <= (state_d == POP);
      win_valid_q <= (state_d == OUT);
      busy_q      <= (state_d != IDLE);
`ifdef FIFO_WINDOW_READER_SUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus_if.pop        = pop_q;
  assign bus_if.win_data   = win_data_q;
  assign bus_if.win_valid  = win_valid_q;
  assign bus_if.busy       = busy_q;
  // Pulses during the accepting cycle of the final window only.
  assign bus_if.burst_done = w_handshake & w_last;
`ifdef FIFO_WINDOW_READER_SUM_EN
  assign bus_if.window_sum = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_window_reader.sv
// +--------------------------------------------------------------------------+
// | tb_fifo_window_reader : randomized bench with a FIFO and window model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_window_reader;

  localparam int DW    = 8;
  localparam int TAPS  = 3;
  localparam int BURST = 8;
  localparam int NWIN  = BURST - TAPS + 1;

  logic clk = 1'b0;
  logic reset;

  fifo_window_reader_if #(.DATA_W(DW), .TAPS(TAPS)) bus();

  fifo_window_reader #(.DATA_W(DW), .TAPS(TAPS), .BURST(BURST)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: 1-cycle read latency
  logic [DW-1:0] mem [256];
  logic [7:0]    rd_ptr = 8'd0;
  always @(posedge clk) begin
    if (bus.pop) begin
      bus.fifo_data <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end

  // win_ready driver: 0 = always ready, 1 = random, 2 = manual
  int   mode      = 2;
  logic ready_man = 1'b0;
  initial begin
    bus.win_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       bus.win_ready = 1'b1;
        1:       bus.win_ready = ($urandom_range(0, 99) < 60);
        default: bus.win_ready = ready_man;
      endcase
    end
  end

  // Reference: window k of a burst starting at FIFO index b is samples b+k .. b+k+TAPS-1
  function automatic logic [TAPS*DW-1:0] model_window(input int b, input int kk);
    logic [TAPS*DW-1:0] w;
    w = '0;
    for (int j = 0; j < TAPS; j++) w[(TAPS-1-j)*DW +: DW] = mem[(b + kk + j) % 256];
    return w;
  endfunction

  function automatic int model_sum(input int b, input int kk);
    int s;
    s = 0;
    for (int j = 0; j < TAPS; j++) s += int'(mem[(b + kk + j) % 256]);
    return s;
  endfunction

  bit                 in_burst = 0;
  int                 base = 0, k = 0, pops_in_burst = 0;
  int                 pop_total = 0, windows_total = 0, bursts_done = 0;
  bit                 prev_stall = 0, pop_d1 = 0, pop_d2 = 0, last;
  logic [TAPS*DW-1:0] prev_data, first_win, last_win;
  int                 first_sum, last_sum;

  always @(negedge clk) begin
    if (reset) begin
      in_burst   = 0;
      prev_stall = 0;
      pop_d1     = 0;
      pop_d2     = 0;
    end else begin
      check("pop_vs_valid", bus.pop & bus.win_valid, 1'b0);
      if (pop_d1) begin
        check("capt_pop", bus.pop, 1'b0);
        check("capt_valid", bus.win_valid, 1'b0);
      end
      if (pop_d2 && pops_in_burst >= TAPS) check("win_latency", bus.win_valid, 1'b1);
      if (prev_stall) begin
        check("stall_valid", bus.win_valid, 1'b1);
        check("stall_data", bus.win_data, prev_data);
      end
      if (bus.pop) begin
        if (!in_burst) begin
          in_burst      = 1;
          base          = int'(rd_ptr);
          k             = 0;
          pops_in_burst = 0;
        end
        pops_in_burst++;
        pop_total++;
        check("pops_le_burst", pops_in_burst <= BURST, 1'b1);
      end
      if (bus.win_valid && bus.win_ready) begin
        check("win_pops", pops_in_burst, k + TAPS);
        check("win_data", bus.win_data, model_window(base, k));
`ifdef FIFO_WINDOW_READER_SUM_EN
        check("win_sum", bus.window_sum, model_sum(base, k));
        if (k == 0) first_sum = int'(bus.window_sum);
        last_sum = int'(bus.window_sum);
`endif
        if (k == 0) first_win = bus.win_data;
        last_win = bus.win_data;
        last = (k == BURST - TAPS);
        check("burst_done", bus.burst_done, last);
        k++;
        windows_total++;
        if (last) begin
          in_burst = 0;
          bursts_done++;
        end
      end else begin
        check("done_quiet", bus.burst_done, 1'b0);
      end
      prev_stall = bus.win_valid && !bus.win_ready;
      prev_data  = bus.win_data;
      pop_d2     = pop_d1;
      pop_d1     = bus.pop;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int budget);
    int p0, cnt;
    p0 = pop_total;
    cnt = 0;
    bus.buffer_full = 1'b1;
    bus.no_config   = 1'b0;
    while (pop_total == p0 && cnt < budget) begin
      tick();
      cnt++;
    end
    check("burst_start", pop_total != p0, 1'b1);
    bus.buffer_full = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget);
    int cnt;
    cnt = 0;
    while (bursts_done == start && cnt < budget) begin
      tick();
      cnt++;
    end
    check("burst_end", bursts_done, start + 1);
  endtask

  task automatic after_burst(input int w0);
    int p;
    check("burst_windows", windows_total - w0, NWIN);
    p = pop_total;
    repeat (3) tick();
    check("idle_busy", bus.busy, 1'b0);
    check("idle_pops", pop_total, p);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pop"}, bus.pop, 1'b0);
    check({tag, "_valid"}, bus.win_valid, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.burst_done, 1'b0);
    check({tag, "_data"}, bus.win_data, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, w0, p0, cnt;
    bit saw_busy;
    for (int i = 0; i < 256; i++) mem[i] = (i < 16) ? 8'(8'h0A + (i % 8)) : 8'($urandom);
    reset           = 1'b1;
    bus.buffer_full = 1'b0;
    bus.no_config   = 1'b1;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    tick();
    reset = 1'b0;

    // Unconfigured FIFO never starts a burst
    bus.buffer_full = 1'b1;
    p0 = pop_total;
    saw_busy = 0;
    repeat (20) begin
      tick();
      saw_busy |= bus.busy;
    end
    check("noconf_pops", pop_total, p0);
    check("noconf_busy", saw_busy, 1'b0);

    // Free-flowing burst
    mode = 0;
    s = bursts_done;
    w0 = windows_total;
    start_burst(50);
    wait_done(s, 200);
    check("s3_first", first_win, 24'h0A0B0C);
    check("s3_last", last_win, 24'h0F1011);
`ifdef FIFO_WINDOW_READER_SUM_EN
    check("s3_first_sum", first_sum, 33);
    check("s3_last_sum", last_sum, 48);
`endif
    after_burst(w0);

    // Back-pressure on the first window
    mode = 2;
    ready_man = 1'b0;
    repeat (2) tick();
    s = bursts_done;
    w0 = windows_total;
    start_burst(50);
    cnt = 0;
    while (!bus.win_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    check("s4_valid", bus.win_valid, 1'b1);
    p0 = pop_total;
    repeat (5) begin
      tick();
      check("s4_hold", bus.win_data, 24'h0A0B0C);
    end
    check("s4_no_pop", pop_total, p0);
    mode = 0;
    wait_done(s, 200);
    check("s4_first", first_win, 24'h0A0B0C);
    check("s4_last", last_win, 24'h0F1011);
    after_burst(w0);

    // Reset after the 4th pop
    bus.buffer_full = 1'b1;
    bus.no_config   = 1'b0;
    cnt = 0;
    while (!(in_burst && pops_in_burst == 4) && cnt < 100) begin
      tick();
      if (bus.pop) bus.buffer_full = 1'b0;
      cnt++;
    end
    bus.buffer_full = 1'b0;
    check("s5_four_pops", pops_in_burst, 4);
    reset = 1'b1;
    tick();
    check_outputs_zero("s5_rst");
    reset = 1'b0;
    tick();
    s = bursts_done;
    w0 = windows_total;
    start_burst(50);
    wait_done(s, 200);
    after_burst(w0);

    // Randomized bursts with random back-pressure and mid-burst flag noise
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mode = 1;
    for (int b = 0; b < 10; b++) begin
      repeat ($urandom_range(0, 4)) tick();
      s = bursts_done;
      w0 = windows_total;
      start_burst(50);
      cnt = 0;
      while (bursts_done == s && cnt < 600) begin
        if (in_burst && k < BURST - TAPS) begin
          bus.buffer_full = 1'($urandom_range(0, 1));
          bus.no_config   = 1'($urandom_range(0, 1));
        end else begin
          bus.buffer_full = 1'b0;
        end
        tick();
        cnt++;
      end
      check("rand_done", bursts_done, s + 1);
      after_burst(w0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
